// File: rtl/gameconsole_pkg.sv
// Shared VRAM address map, default region depths, region decode and clear-FSM state types.
package gameconsole_pkg;

  localparam logic [31:0] VRAM_PARAM_BASE = 32'h0600_0000;
  localparam logic [31:0] VRAM_MAP_BASE   = 32'h0610_0000;
  localparam logic [31:0] VRAM_TILE_BASE  = 32'h0620_0000;
  localparam logic [31:0] VRAM_PAL_BASE   = 32'h0630_0000;

  localparam int unsigned VRAM_PARAM_DEPTH = 1024;
  localparam int unsigned VRAM_MAP_DEPTH   = 2048;
  localparam int unsigned VRAM_TILE_DEPTH  = 16384;
  localparam int unsigned VRAM_PAL_DEPTH   = 256;
  localparam int unsigned VRAM_TILE_W      = 8;

  typedef enum logic [2:0] {PARAM, MAP, TILE, PAL, NONE} vram_region_e;

  typedef enum logic {StIdle, StClear} vram_clr_state_e;

  function automatic vram_region_e vram_decode(input logic [31:0] addr);
    vram_region_e r;
    case (addr[31:20])
      VRAM_PARAM_BASE[31:20]: r = PARAM;
      VRAM_MAP_BASE[31:20]:   r = MAP;
      VRAM_TILE_BASE[31:20]:  r = TILE;
      VRAM_PAL_BASE[31:20]:   r = PAL;
      default:                r = NONE;
    endcase
    return r;
  endfunction

  // Bit order matches the bank vectors in the top: {pal, tile, map, param}.
  function automatic logic [3:0] vram_region_oh(input vram_region_e r);
    logic [3:0] oh;
    case (r)
      PARAM:   oh = 4'b0001;
      MAP:     oh = 4'b0010;
      TILE:    oh = 4'b0100;
      PAL:     oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/vram_bank.sv
// Dual-port RAM bank: port A read/write, port B read-only, both read-first with registered
// read data that holds while its read enable is low.
module vram_bank #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_we,
  input  logic             a_re,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_re,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] b_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] a_rdata_d, a_rdata_q, b_rdata_d, b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_we) mem_q[a_addr] <= a_wdata;
  end

  // Reads sample the array before this edge's write lands, giving read-first behaviour.
  always_comb begin
    a_rdata_d = a_re ? mem_q[a_addr] : a_rdata_q;
    b_rdata_d = b_re ? mem_q[b_addr] : b_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/vram_bus_responder.sv
// VRAM responder: CPU and video access to four video regions, bulk clear engine, error capture.
// Define VRAM_ERR_CAPTURE_EN to build the sticky out-of-range error capture logic.
module vram_bus_responder
  import gameconsole_pkg::*;
#(
  parameter int unsigned PARAM_DEPTH = VRAM_PARAM_DEPTH,
  parameter int unsigned MAP_DEPTH   = VRAM_MAP_DEPTH,
  parameter int unsigned TILE_DEPTH  = VRAM_TILE_DEPTH,
  parameter int unsigned PAL_DEPTH   = VRAM_PAL_DEPTH,
  parameter int unsigned TILE_W      = VRAM_TILE_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  input  logic        vid_en,
  input  logic [31:0] vid_addr,
  output logic [31:0] vid_dout,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        err_valid,
  output logic [31:0] err_addr,
  output logic        err_we,
  input  logic        err_clr
);

  localparam int unsigned MAX_DEPTH =
      (PARAM_DEPTH > MAP_DEPTH ? PARAM_DEPTH : MAP_DEPTH) > (TILE_DEPTH > PAL_DEPTH ?
      TILE_DEPTH : PAL_DEPTH) ? (PARAM_DEPTH > MAP_DEPTH ? PARAM_DEPTH : MAP_DEPTH) :
      (TILE_DEPTH > PAL_DEPTH ? TILE_DEPTH : PAL_DEPTH);
  localparam int unsigned ADDR_W   = $clog2(MAX_DEPTH);
  localparam int unsigned PARAM_AW = $clog2(PARAM_DEPTH);
  localparam int unsigned MAP_AW   = $clog2(MAP_DEPTH);
  localparam int unsigned TILE_AW  = $clog2(TILE_DEPTH);
  localparam int unsigned PAL_AW   = $clog2(PAL_DEPTH);

  function automatic logic in_range(input vram_region_e r, input logic [19:0] off);
    logic [31:0] o;
    logic        ok;
    o = {12'd0, off};
    case (r)
      PARAM:   ok = o < PARAM_DEPTH;
      MAP:     ok = o < MAP_DEPTH;
      TILE:    ok = o < TILE_DEPTH;
      PAL:     ok = o < PAL_DEPTH;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  vram_region_e    cpu_reg, vid_reg, cpu_sel_d, cpu_sel_q, vid_sel_d, vid_sel_q;
  vram_clr_state_e state_d, state_q;
  logic              cpu_ok, vid_ok, clearing;
  logic [3:0]        a_we, a_re, b_re;
  logic [ADDR_W-1:0] a_addr, clr_cnt_d, clr_cnt_q;
  logic [31:0]       a_wdata;
  logic [31:0]       param_a_rdata, param_b_rdata, map_a_rdata, map_b_rdata;
  logic [31:0]       pal_a_rdata, pal_b_rdata;
  logic [TILE_W-1:0] tile_a_rdata, tile_b_rdata;

  assign cpu_reg  = vram_decode(mem_addr);
  assign vid_reg  = vram_decode(vid_addr);
  assign cpu_ok   = in_range(cpu_reg, mem_addr[19:0]);
  assign vid_ok   = in_range(vid_reg, vid_addr[19:0]);
  assign clearing = (state_q == StClear);
  assign clr_busy = clearing;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(MAX_DEPTH - 1)) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The clear engine owns port A of every bank; CPU traffic is dropped and reads return 0.
  always_comb begin
    a_we      = '0;
    a_re      = '0;
    a_addr    = mem_addr[ADDR_W-1:0];
    a_wdata   = mem_din;
    cpu_sel_d = cpu_sel_q;
    if (clearing) begin
      a_addr  = clr_cnt_q;
      a_wdata = '0;
      a_we[0] = 32'(clr_cnt_q) < PARAM_DEPTH;
      a_we[1] = 32'(clr_cnt_q) < MAP_DEPTH;
      a_we[2] = 32'(clr_cnt_q) < TILE_DEPTH;
      a_we[3] = 32'(clr_cnt_q) < PAL_DEPTH;
      if (mem_en && !mem_we) cpu_sel_d = NONE;
    end else if (mem_en) begin
      a_we = {4{mem_we && cpu_ok}} & vram_region_oh(cpu_reg);
      a_re = {4{!mem_we && cpu_ok}} & vram_region_oh(cpu_reg);
      if (!mem_we) cpu_sel_d = cpu_ok ? cpu_reg : NONE;
    end
  end

  always_comb begin
    b_re      = {4{vid_en && vid_ok}} & vram_region_oh(vid_reg);
    vid_sel_d = vid_sel_q;
    if (vid_en) vid_sel_d = vid_ok ? vid_reg : NONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
      cpu_sel_q <= NONE;
      vid_sel_q <= NONE;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cpu_sel_q <= cpu_sel_d;
      vid_sel_q <= vid_sel_d;
    end
  end

  always_comb begin
    case (cpu_sel_q)
      PARAM:   mem_dout = param_a_rdata;
      MAP:     mem_dout = map_a_rdata;
      TILE:    mem_dout = {{(32-TILE_W){1'b0}}, tile_a_rdata};
      PAL:     mem_dout = pal_a_rdata;
      default: mem_dout = '0;
    endcase
    case (vid_sel_q)
      PARAM:   vid_dout = param_b_rdata;
      MAP:     vid_dout = map_b_rdata;
      TILE:    vid_dout = {{(32-TILE_W){1'b0}}, tile_b_rdata};
      PAL:     vid_dout = pal_b_rdata;
      default: vid_dout = '0;
    endcase
  end

  vram_bank #(.DEPTH(PARAM_DEPTH), .WIDTH(32)) u_param_bank (
    .clk(clk), .rst_n(rst_n),
    .a_we(a_we[0]), .a_re(a_re[0]), .a_addr(a_addr[PARAM_AW-1:0]), .a_wdata(a_wdata),
    .a_rdata(param_a_rdata),
    .b_re(b_re[0]), .b_addr(vid_addr[PARAM_AW-1:0]), .b_rdata(param_b_rdata)
  );

  vram_bank #(.DEPTH(MAP_DEPTH), .WIDTH(32)) u_map_bank (
    .clk(clk), .rst_n(rst_n),
    .a_we(a_we[1]), .a_re(a_re[1]), .a_addr(a_addr[MAP_AW-1:0]), .a_wdata(a_wdata),
    .a_rdata(map_a_rdata),
    .b_re(b_re[1]), .b_addr(vid_addr[MAP_AW-1:0]), .b_rdata(map_b_rdata)
  );

  vram_bank #(.DEPTH(TILE_DEPTH), .WIDTH(TILE_W)) u_tile_bank (
    .clk(clk), .rst_n(rst_n),
    .a_we(a_we[2]), .a_re(a_re[2]), .a_addr(a_addr[TILE_AW-1:0]),
    .a_wdata(a_wdata[TILE_W-1:0]), .a_rdata(tile_a_rdata),
    .b_re(b_re[2]), .b_addr(vid_addr[TILE_AW-1:0]), .b_rdata(tile_b_rdata)
  );

  vram_bank #(.DEPTH(PAL_DEPTH), .WIDTH(32)) u_pal_bank (
    .clk(clk), .rst_n(rst_n),
    .a_we(a_we[3]), .a_re(a_re[3]), .a_addr(a_addr[PAL_AW-1:0]), .a_wdata(a_wdata),
    .a_rdata(pal_a_rdata),
    .b_re(b_re[3]), .b_addr(vid_addr[PAL_AW-1:0]), .b_rdata(pal_b_rdata)
  );

`ifdef VRAM_ERR_CAPTURE_EN
  logic        err_event, err_valid_d, err_valid_q, err_we_d, err_we_q;
  logic [31:0] err_addr_d, err_addr_q;

  // A new error in the same cycle as err_clr is captured rather than cleared.
  always_comb begin
    err_event   = mem_en && !cpu_ok && !clearing;
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_we_d    = err_we_q;
    if (err_event && (!err_valid_q || err_clr)) begin
      err_valid_d = 1'b1;
      err_addr_d  = mem_addr;
      err_we_d    = mem_we;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_we_q    <= 1'b0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_we_q    <= err_we_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_we    = err_we_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_valid      = 1'b0;
  assign err_addr       = '0;
  assign err_we         = 1'b0;
`endif

endmodule
